// File: rtl/rotate_inverse_top.sv
// Inverse lane rotation: loads 64 slice lines, then writes them back
// with each lane shifted back by its offset along z.
module rotate_inverse_top #(
   parameter int LANES  = 25,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              unrotate_en,
   output logic [ADDR_W-1:0] cnt_value,
   input  logic [LANES-1:0]  line_in,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_addr,
   output logic [LANES-1:0]  write_value,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE,
      S_WAIT_LOW
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   // Per-lane z offset, indexed by 5*y+x.
   localparam logic [ADDR_W-1:0] ROT [25] = '{
      6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
      6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
      6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
      6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
      6'd18, 6'd2,  6'd61, 6'd56, 6'd14
   };

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [LANES-1:0]  buf_q [DEPTH];
   logic [LANES-1:0]  buf_d [DEPTH];
   logic              load_en;
   logic              we;
   logic              done_o;
   logic [LANES-1:0]  rot_line;

   // Sequencer: next state, counters and strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      waddr_d = waddr_q;
      load_en = 1'b0;
      we      = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            waddr_d = '0;
            if (unrotate_en) state_d = S_LOAD;
         end
         S_LOAD: begin
            load_en = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_WRITE;
         end
         S_WRITE: begin
            we      = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (waddr_q == LAST) state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (!unrotate_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line buffer capture during LOAD.
   always_comb begin
      buf_d = buf_q;
      if (load_en) buf_d[cnt_q] = line_in;
   end

   // Un-rotate: each lane picks its bit from line z + r, wrapping.
   always_comb begin
      rot_line = '0;
      for (int i = 0; i < LANES; i++) begin
         rot_line[i] = buf_q[waddr_q + ROT[i]][i];
      end
   end

   // State, counters and buffer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         waddr_q <= '0;
         buf_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         buf_q   <= buf_d;
      end
   end

   assign cnt_value    = cnt_q;
   assign write_addr   = waddr_q;
   assign write_enable = we;
   assign write_value  = we ? rot_line : '0;
   assign done         = done_o;

endmodule

// File: tb/tb_rotate_inverse_top.sv
// Directed bench for rotate_inverse_top: latency, single lanes,
// wrap, round trip, level hold and mid-run reset.
module tb_rotate_inverse_top;

   logic        clk;
   logic        rst_n;
   logic        unrotate_en;
   logic [5:0]  cnt_value;
   logic [24:0] line_in;
   logic        write_enable;
   logic [5:0]  write_addr;
   logic [24:0] write_value;
   logic        done;

   logic [24:0] mem  [64];
   logic [24:0] orig [64];
   logic [24:0] got  [64];

   int n_cmp;
   int n_bad;

   int r_tab [25] = '{
      0,  1,  62, 28, 27,
      36, 44, 6,  55, 20,
      3,  10, 43, 25, 39,
      41, 45, 15, 21, 8,
      18, 2,  61, 56, 14
   };

   rotate_inverse_top dut (
      .clk          (clk),
      .rst          (rst_n),
      .unrotate_en  (unrotate_en),
      .cnt_value    (cnt_value),
      .line_in      (line_in),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_value  (write_value),
      .done         (done)
   );

   assign line_in = mem[cnt_value];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_mem();
      for (int z = 0; z < 64; z++) mem[z] = '0;
   endtask

   // Start a run and record writes; n counts edges after the start edge.
   task automatic do_run(input bit wiggle,
                         output int wr_cnt, output int first_wr,
                         output int done_cyc, output int done_cnt,
                         output int order_err);
      int exp_addr;
      wr_cnt = 0; first_wr = -1; done_cyc = -1;
      done_cnt = 0; order_err = 0; exp_addr = 0;
      for (int z = 0; z < 64; z++) got[z] = 'x;
      @(negedge clk);
      unrotate_en = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 140; n++) begin
         @(negedge clk);
         if (wiggle && (n == 10 || n == 80)) unrotate_en = 1'b0;
         if (wiggle && (n == 12 || n == 82)) unrotate_en = 1'b1;
         if (write_enable) begin
            if (first_wr < 0) first_wr = n + 1;
            if (write_addr !== exp_addr[5:0]) order_err++;
            got[write_addr] = write_value;
            exp_addr++;
            wr_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = n + 1;
            if (write_enable) order_err++;
         end
         @(posedge clk);
      end
   endtask

   task automatic drop_en();
      @(negedge clk);
      unrotate_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({cnt_value, write_enable, write_addr, write_value, done} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h need 0",
                  {cnt_value, write_enable, write_addr, write_value, done});
      end
   endtask

   task automatic test_zero();
      int wc, fw, dc, dn, oe, bad;
      clear_mem();
      do_run(1'b0, wc, fw, dc, dn, oe);
      n_cmp++;
      if (wc !== 64) begin
         n_bad++; $display("FAIL zero_wr_count: got %0d need 64", wc);
      end
      n_cmp++;
      if (fw !== 65) begin
         n_bad++; $display("FAIL zero_first_write: got %0d need 65", fw);
      end
      n_cmp++;
      if (dc !== 129) begin
         n_bad++; $display("FAIL zero_done_cycle: got %0d need 129", dc);
      end
      n_cmp++;
      if (dn !== 1) begin
         n_bad++; $display("FAIL zero_done_count: got %0d need 1", dn);
      end
      n_cmp++;
      if (oe !== 0) begin
         n_bad++; $display("FAIL zero_addr_order: got %0d errs need 0", oe);
      end
      bad = 0;
      for (int z = 0; z < 64; z++) if (got[z] !== 25'd0) bad++;
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL zero_lines: got %0d bad lines need 0", bad);
      end
      drop_en();
   endtask

   task automatic test_single_lane();
      int wc, fw, dc, dn, oe, bad;
      clear_mem();
      mem[1] = 25'b10;
      do_run(1'b0, wc, fw, dc, dn, oe);
      n_cmp++;
      if (got[0] !== 25'b10) begin
         n_bad++; $display("FAIL lane1_line0: got %h need 0000002", got[0]);
      end
      bad = 0;
      for (int z = 1; z < 64; z++) if (got[z] !== 25'd0) bad++;
      n_cmp++;
      if (bad !== 0 || wc !== 64) begin
         n_bad++;
         $display("FAIL lane1_others: got %0d bad, %0d writes need 0, 64", bad, wc);
      end
      drop_en();
   endtask

   task automatic test_wrap();
      int wc, fw, dc, dn, oe, bad;
      clear_mem();
      mem[0] = 25'b100;
      do_run(1'b0, wc, fw, dc, dn, oe);
      n_cmp++;
      if (got[2] !== 25'b100) begin
         n_bad++; $display("FAIL wrap_line2: got %h need 0000004", got[2]);
      end
      bad = 0;
      for (int z = 0; z < 64; z++) if (z != 2 && got[z] !== 25'd0) bad++;
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL wrap_others: got %0d bad lines need 0", bad);
      end
      drop_en();
   endtask

   // Forward-rotate a random state into mem, keep the original.
   task automatic make_rotated();
      for (int z = 0; z < 64; z++) orig[z] = 25'($urandom);
      for (int z = 0; z < 64; z++) begin
         for (int i = 0; i < 25; i++) begin
            mem[z][i] = orig[(z - r_tab[i] + 64) % 64][i];
         end
      end
   endtask

   task automatic test_round_trip(input int k, input bit wiggle);
      int wc, fw, dc, dn, oe, bad;
      make_rotated();
      do_run(wiggle, wc, fw, dc, dn, oe);
      bad = 0;
      for (int z = 0; z < 64; z++) if (got[z] !== orig[z]) bad++;
      n_cmp++;
      if (bad !== 0 || wc !== 64 || dn !== 1) begin
         n_bad++;
         $display("FAIL round_trip_%0d: got %0d bad, %0d writes, %0d done need 0, 64, 1",
                  k, bad, wc, dn);
      end
      drop_en();
   endtask

   task automatic test_hold_level();
      int wc, fw, dc, dn, oe, extra;
      clear_mem();
      mem[5] = 25'h1;
      do_run(1'b0, wc, fw, dc, dn, oe);
      extra = 0;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         if (write_enable || done || cnt_value !== 6'd0) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++; $display("FAIL hold_no_retrigger: got %0d active cycles need 0", extra);
      end
      drop_en();
      do_run(1'b0, wc, fw, dc, dn, oe);
      n_cmp++;
      if (wc !== 64 || dn !== 1 || got[5] !== 25'h1) begin
         n_bad++;
         $display("FAIL hold_second_run: got %0d writes, %0d done, line5 %h need 64, 1, 0000001",
                  wc, dn, got[5]);
      end
      drop_en();
   endtask

   task automatic test_reset_mid();
      bit hit;
      int leak;
      make_rotated();
      hit = 1'b0;
      @(negedge clk);
      unrotate_en = 1'b1;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         if (write_enable && write_addr == 6'd20) hit = 1'b1;
      end
      n_cmp++;
      if (!hit) begin
         n_bad++; $display("FAIL midreset_reach_addr20: got timeout need addr 20");
      end
      rst_n = 1'b0;
      unrotate_en = 1'b0;
      #1;
      n_cmp++;
      if ({cnt_value, write_enable, write_addr, write_value, done} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %h need 0",
                  {cnt_value, write_enable, write_addr, write_value, done});
      end
      leak = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (write_enable) leak++;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (write_enable || done) leak++;
      end
      n_cmp++;
      if (leak !== 0) begin
         n_bad++; $display("FAIL midreset_no_writes: got %0d need 0", leak);
      end
      test_round_trip(9, 1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      unrotate_en = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_zero();
      test_single_lane();
      test_wrap();
      test_round_trip(1, 1'b0);
      test_round_trip(2, 1'b1);
      test_round_trip(3, 1'b0);
      test_hold_level();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
